// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Each op runs one shift-add or restoring-subtract step per cycle on operand magnitudes, then applies a one-cycle sign fix.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return -v;
        end else begin
            return v;
        end
    endfunction

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic             op_div;
    logic             neg_res;
    logic             neg_rem;
    logic             div_zero;

    logic             signed_op;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_rem;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;
    logic [2*WIDTH-1:0] product;

    assign busy      = (state != IDLE);
    assign signed_op = ~funct[0];

    // One iteration: mul shifts {acc_hi,acc_lo} right after a conditional add; div shifts left and trial-subtracts.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_rem   = div_shift[WIDTH-1:0] - opb;
        div_ge    = (div_shift >= {1'b0, opb});
        step_hi   = '0;
        step_lo   = '0;
        if (op_div) begin
            if (div_ge) begin
                step_hi = div_rem;
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_shift[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction of the magnitude result; a zero divisor leaves the dividend in the remainder.
    always_comb begin
        product = {acc_hi, acc_lo};
        fix_hi  = '0;
        fix_lo  = '0;
        if (op_div) begin
            fix_hi = neg_rem ? -acc_hi : acc_hi;
            if (div_zero) begin
                fix_lo = '1;
            end else begin
                fix_lo = neg_res ? -acc_lo : acc_lo;
            end
        end else begin
            {fix_hi, fix_lo} = neg_res ? -product : product;
        end
    end

    // Control FSM, datapath registers and architectural HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            op_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            case (funct)
                                F_MTHI: hi <= srca;
                                F_MTLO: lo <= srca;
                                F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                                    op_div   <= funct[1];
                                    acc_hi   <= '0;
                                    acc_lo   <= magnitude(srca, signed_op);
                                    opb      <= magnitude(srcb, signed_op);
                                    neg_res  <= signed_op & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                                    neg_rem  <= signed_op & srca[WIDTH-1];
                                    div_zero <= (srcb == '0);
                                    count    <= '0;
                                    state    <= ITER;
                                end
                                default: state <= IDLE;
                            endcase
                        end
                    end
                    ITER: begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count + 1'b1;
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end
                    end
                    FIX: begin
                        hi    <= fix_hi;
                        lo    <= fix_lo;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised scoreboard bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, flush;
    logic [5:0]   funct;
    logic [W-1:0] srca, srcb;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic [W-1:0] hi_m, lo_m;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .srca(srca), .srcb(srcb), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain signed/unsigned arithmetic, returns {hi,lo}
    function automatic logic [63:0] ref_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            6'b011000: begin p = sa * sb; return p; end
            6'b011001: begin p = {32'd0, a} * {32'd0, b}; return p; end
            6'b011010: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            6'b011011: begin
                if (b == 32'd0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return {hi_m, lo_m};
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, e[63:32]});
                chk("lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    // Issue a MULT*/DIV* at a negedge and wait for busy to drop; optionally poke a MTHI mid-op
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit poke);
        int cnt;
        logic [63:0] e;
        e = ref_model(f, a, b);
        exp_q.push_back(e);
        {hi_m, lo_m} = e;
        start = 1'b1; funct = f; srca = a; srcb = b;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        while (busy && cnt < 200) begin
            cnt++;
            if (poke && cnt == 5) begin
                start = 1'b1; funct = 6'b010001; srca = $urandom;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_cycles", 64'(cnt), 64'(W + 1));
    endtask

    task automatic run_mt(input logic [5:0] f, input logic [31:0] a);
        start = 1'b1; funct = f; srca = a;
        if (f == 6'b010001) hi_m = a; else lo_m = a;
        @(negedge clk);
        start = 1'b0;
        chk("mt_busy", {63'd0, busy}, 64'd0);
        chk("mt_hilo", {hi, lo}, {hi_m, lo_m});
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] ops [6];
        int k;
        ops = '{6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010001, 6'b010011};
        reset = 1'b1; start = 1'b0; flush = 1'b0; funct = 6'd0; srca = '0; srcb = '0;
        hi_m = '0; lo_m = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy_done", {62'd0, busy, done}, 64'd0);

        run_op(6'b011000, 32'hFFFFFFFD, 32'd7, 1'b0);
        run_op(6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(6'b011010, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(6'b011011, 32'd7, 32'd0, 1'b0);
        run_op(6'b011010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(6'b011010, 32'hFFFFFFF9, 32'd0, 1'b0);
        run_mt(6'b010011, 32'd5);
        run_op(6'b011000, 32'h12345678, 32'h9ABCDEF0, 1'b1);

        // unknown funct is ignored
        start = 1'b1; funct = 6'b100000; srca = 32'hDEADBEEF;
        @(negedge clk);
        start = 1'b0;
        chk("bad_funct_hilo", {hi, lo}, {hi_m, lo_m});
        chk("bad_funct_busy", {63'd0, busy}, 64'd0);

        // flush together with MTLO: nothing written
        start = 1'b1; flush = 1'b1; funct = 6'b010011; srca = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_mt_hilo", {hi, lo}, {hi_m, lo_m});

        // DIV flushed at ITER cycle 10: back to idle, no done, HI/LO held
        start = 1'b1; funct = 6'b011010; srca = 32'd1000; srcb = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hilo", {hi, lo}, {hi_m, lo_m});

        for (int i = 0; i < 40; i++) begin
            k = $urandom_range(0, 5);
            if (k >= 4) run_mt(ops[k], $urandom);
            else run_op(ops[k], pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));
        end

        // reset mid-ITER discards the op and clears HI/LO
        start = 1'b1; funct = 6'b011000; srca = 32'd9; srcb = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("midreset_hilo", {hi, lo}, 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
